pwm_gen: RTL and testbench

PWM_GEN -- requirements
Module: pwm_gen

---
 rtl/pwm_gen.sv | 205 ++++++++++++++++++++
 tb/tb_pwm_gen.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pwm_gen.sv
// pwm_gen: tick-driven PWM generator with an IDLE/RUN/STOP control FSM.
// The period/duty pair is double-buffered. While idle a new configuration
// loads straight into the active registers. While running it waits in a
// shadow register and is applied only at a period wrap, so a period that
// has already started is never altered. STOP finishes the current period
// and then parks the block in IDLE.
module pwm_gen #(
  parameter int WIDTH      = 8,
  parameter int PERIOD_DEF = 3,
  parameter int DUTY_DEF   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_en,
  input  logic             enable,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_period,
  input  logic [WIDTH-1:0] cfg_duty,
  output logic             cfg_ready,
  output logic             pwm_o,
  output logic             period_done_o,
  output logic [WIDTH-1:0] cnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] PERIOD_RST = WIDTH'(PERIOD_DEF);
  localparam logic [WIDTH-1:0] DUTY_RST   = WIDTH'(DUTY_DEF);
  localparam logic [WIDTH-1:0] ZERO_W     = {WIDTH{1'b0}};

  // Registered state.
  state_t           state_r;
  logic [WIDTH-1:0] cnt_r;
  logic             pwm_r;
  logic             done_r;
  logic             ready_r;
  logic             pending_r;
  logic [WIDTH-1:0] period_act_r;
  logic [WIDTH-1:0] duty_act_r;
  logic [WIDTH-1:0] period_shd_r;
  logic [WIDTH-1:0] duty_shd_r;

  // Next-state values.
  state_t           state_s;
  logic [WIDTH-1:0] cnt_s;
  logic             pwm_s;
  logic             done_s;
  logic             ready_s;
  logic             pending_s;
  logic [WIDTH-1:0] period_act_s;
  logic [WIDTH-1:0] duty_act_s;
  logic [WIDTH-1:0] period_shd_s;
  logic [WIDTH-1:0] duty_shd_s;

  // Helper terms.
  logic             cfg_accept_s;
  logic             wrap_s;
  logic [WIDTH:0]   cnt_inc_s;

  // Handshake, wrap detection and the widened increment used for the duty
  // compare. The increment is one bit wider so the compare stays exact at
  // the top of the range.
  always_comb begin
    cfg_accept_s = cfg_valid & ready_r;
    wrap_s       = (cnt_r >= period_act_r);
    cnt_inc_s    = {1'b0, cnt_r} + {{WIDTH{1'b0}}, 1'b1};
  end

  // Next-state and next-output logic for the control FSM and datapath.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    pwm_s        = pwm_r;
    done_s       = 1'b0;
    pending_s    = pending_r;
    period_act_s = period_act_r;
    duty_act_s   = duty_act_r;
    period_shd_s = period_shd_r;
    duty_shd_s   = duty_shd_r;

    case (state_r)
      ST_IDLE: begin
        cnt_s = ZERO_W;
        pwm_s = 1'b0;
        // A direct load supersedes any shadow left over from the STOP wrap.
        // Otherwise a leftover shadow is applied as the block starts.
        if (cfg_accept_s) begin
          period_act_s = cfg_period;
          duty_act_s   = cfg_duty;
          pending_s    = 1'b0;
        end else if (pending_r && tick_en && enable) begin
          period_act_s = period_shd_r;
          duty_act_s   = duty_shd_r;
          pending_s    = 1'b0;
        end else begin
          pending_s = pending_r;
        end
        if (tick_en && enable) begin
          state_s = ST_RUN;
          cnt_s   = ZERO_W;
          pwm_s   = (ZERO_W < duty_act_s);
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_RUN, ST_STOP: begin
        // enable is level-sensitive. It selects RUN or STOP on every edge,
        // and counting continues in both states.
        if (enable) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_STOP;
        end

        if (tick_en) begin
          if (wrap_s) begin
            cnt_s  = ZERO_W;
            done_s = 1'b1;
            // The shadow is applied only if it was pending before this edge.
            // A config accepted on this same edge waits for the next wrap.
            if (pending_r) begin
              period_act_s = period_shd_r;
              duty_act_s   = duty_shd_r;
              pending_s    = 1'b0;
            end else begin
              pending_s = 1'b0;
            end
            if ((state_r == ST_STOP) && !enable) begin
              state_s = ST_IDLE;
              pwm_s   = 1'b0;
            end else begin
              pwm_s = (ZERO_W < duty_act_s);
            end
          end else begin
            cnt_s = cnt_inc_s[WIDTH-1:0];
            pwm_s = (cnt_inc_s < {1'b0, duty_act_r});
          end
        end else begin
          cnt_s = cnt_r;
          pwm_s = pwm_r;
        end

        // A new offer is only possible while nothing is pending, so this
        // never overwrites a shadow that is still waiting to be applied.
        if (cfg_accept_s) begin
          period_shd_s = cfg_period;
          duty_shd_s   = cfg_duty;
          pending_s    = 1'b1;
        end else begin
          period_shd_s = period_shd_r;
          duty_shd_s   = duty_shd_r;
        end
      end

      default: begin
        state_s   = ST_IDLE;
        cnt_s     = ZERO_W;
        pwm_s     = 1'b0;
        pending_s = 1'b0;
      end
    endcase

    // cfg_ready is registered. It is open whenever the block is idle, or
    // whenever no shadow is waiting to be applied.
    ready_s = (state_s == ST_IDLE) | ~pending_s;
  end

  // State and datapath registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      cnt_r        <= ZERO_W;
      pwm_r        <= 1'b0;
      done_r       <= 1'b0;
      ready_r      <= 1'b1;
      pending_r    <= 1'b0;
      period_act_r <= PERIOD_RST;
      duty_act_r   <= DUTY_RST;
      period_shd_r <= PERIOD_RST;
      duty_shd_r   <= DUTY_RST;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      pwm_r        <= pwm_s;
      done_r       <= done_s;
      ready_r      <= ready_s;
      pending_r    <= pending_s;
      period_act_r <= period_act_s;
      duty_act_r   <= duty_act_s;
      period_shd_r <= period_shd_s;
      duty_shd_r   <= duty_shd_s;
    end
  end

  assign cnt_o         = cnt_r;
  assign pwm_o         = pwm_r;
  assign period_done_o = done_r;
  assign cfg_ready     = ready_r;

endmodule

// File: tb/tb_pwm_gen.sv
// tb_pwm_gen: directed, table-driven bench for pwm_gen (default parameters),
// plus hand-written sequences for the divided tick stream and async reset.
module tb_pwm_gen;

  logic       clk;
  logic       rst;
  logic       tick_en;
  logic       enable;
  logic       cfg_valid;
  logic [7:0] cfg_period;
  logic [7:0] cfg_duty;
  logic       cfg_ready;
  logic       pwm_o;
  logic       period_done_o;
  logic [7:0] cnt_o;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       t;
    logic       e;
    logic       v;
    logic [7:0] p;
    logic [7:0] d;
    logic       ep;
    logic       ed;
    logic [7:0] ec;
    logic       er;
  } vec_t;

  vec_t vecs[$];

  pwm_gen #(.WIDTH(8), .PERIOD_DEF(3), .DUTY_DEF(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .tick_en      (tick_en),
    .enable       (enable),
    .cfg_valid    (cfg_valid),
    .cfg_period   (cfg_period),
    .cfg_duty     (cfg_duty),
    .cfg_ready    (cfg_ready),
    .pwm_o        (pwm_o),
    .period_done_o(period_done_o),
    .cnt_o        (cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic ep, input logic ed,
                         input logic [7:0] ec, input logic er);
    chk({nm, "_pwm"}, {31'd0, pwm_o}, {31'd0, ep});
    chk({nm, "_done"}, {31'd0, period_done_o}, {31'd0, ed});
    chk({nm, "_cnt"}, {24'd0, cnt_o}, {24'd0, ec});
    chk({nm, "_ready"}, {31'd0, cfg_ready}, {31'd0, er});
  endtask

  // Drive one edge's inputs at the negedge, then check 1 ns after the posedge.
  task automatic step(input logic t, input logic e, input logic v,
                      input logic [7:0] p, input logic [7:0] d,
                      input logic ep, input logic ed, input logic [7:0] ec,
                      input logic er, input string nm);
    @(negedge clk);
    tick_en = t; enable = e; cfg_valid = v; cfg_period = p; cfg_duty = d;
    @(posedge clk);
    #1;
    chk_all(nm, ep, ed, ec, er);
  endtask

  task automatic add(input logic t, input logic e, input logic v,
                     input logic [7:0] p, input logic [7:0] d,
                     input logic ep, input logic ed, input logic [7:0] ec,
                     input logic er);
    vec_t r;
    r.t = t; r.e = e; r.v = v; r.p = p; r.d = d;
    r.ep = ep; r.ed = ed; r.ec = ec; r.er = er;
    vecs.push_back(r);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; tick_en = 1'b0; enable = 1'b0; cfg_valid = 1'b0;
    cfg_period = 8'd0; cfg_duty = 8'd0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; tick_en = 1'b0; enable = 1'b0; cfg_valid = 1'b0;
    cfg_period = 8'd0; cfg_duty = 8'd0;

    // Vector table: t e v period duty | pwm done cnt ready
    add(1'b0,1'b1,1'b0,8'd0,8'd0, 1'b0,1'b0,8'd0,1'b1);      // idle, no tick
    add(1'b1,1'b1,1'b0,8'd0,8'd0, 1'b1,1'b0,8'd0,1'b1);      // start
    add(1'b0,1'b1,1'b0,8'd0,8'd0, 1'b1,1'b0,8'd0,1'b1);      // hold
    for (int c = 1; c <= 3; c++)
      add(1'b1,1'b1,1'b0,8'd0,8'd0, (c < 2),1'b0,8'(c),1'b1);
    add(1'b1,1'b1,1'b0,8'd0,8'd0, 1'b1,1'b1,8'd0,1'b1);      // wrap
    add(1'b0,1'b1,1'b0,8'd0,8'd0, 1'b1,1'b0,8'd0,1'b1);
    add(1'b1,1'b1,1'b0,8'd0,8'd0, 1'b1,1'b0,8'd1,1'b1);
    add(1'b0,1'b1,1'b1,8'd7,8'd5, 1'b1,1'b0,8'd1,1'b0);      // (7,5) mid-period
    for (int c = 2; c <= 3; c++)
      add(1'b1,1'b1,1'b0,8'd0,8'd0, 1'b0,1'b0,8'(c),1'b0);
    add(1'b1,1'b1,1'b0,8'd0,8'd0, 1'b1,1'b1,8'd0,1'b1);      // apply (7,5)
    for (int c = 1; c <= 7; c++)
      add(1'b1,1'b1,1'b0,8'd0,8'd0, (c < 5),1'b0,8'(c),1'b1);
    add(1'b1,1'b1,1'b0,8'd0,8'd0, 1'b1,1'b1,8'd0,1'b1);
    for (int c = 1; c <= 7; c++)
      add(1'b1,1'b1,1'b0,8'd0,8'd0, (c < 5),1'b0,8'(c),1'b1);
    add(1'b1,1'b1,1'b1,8'd3,8'd2, 1'b1,1'b1,8'd0,1'b0);      // cfg on wrap edge
    for (int c = 1; c <= 7; c++)
      add(1'b1,1'b1,1'b0,8'd0,8'd0, (c < 5),1'b0,8'(c),1'b0); // old (7,5) again
    add(1'b1,1'b1,1'b0,8'd0,8'd0, 1'b1,1'b1,8'd0,1'b1);      // apply (3,2)
    add(1'b1,1'b1,1'b0,8'd0,8'd0, 1'b1,1'b0,8'd1,1'b1);
    add(1'b0,1'b0,1'b0,8'd0,8'd0, 1'b1,1'b0,8'd1,1'b1);      // drop enable -> STOP
    add(1'b1,1'b0,1'b0,8'd0,8'd0, 1'b0,1'b0,8'd2,1'b1);
    add(1'b1,1'b0,1'b0,8'd0,8'd0, 1'b0,1'b0,8'd3,1'b1);
    add(1'b1,1'b0,1'b0,8'd0,8'd0, 1'b0,1'b1,8'd0,1'b1);      // STOP wrap -> IDLE
    add(1'b0,1'b0,1'b0,8'd0,8'd0, 1'b0,1'b0,8'd0,1'b1);
    add(1'b1,1'b1,1'b0,8'd0,8'd0, 1'b1,1'b0,8'd0,1'b1);      // restart
    add(1'b1,1'b1,1'b0,8'd0,8'd0, 1'b1,1'b0,8'd1,1'b1);
    add(1'b0,1'b0,1'b0,8'd0,8'd0, 1'b1,1'b0,8'd1,1'b1);      // STOP
    add(1'b1,1'b1,1'b0,8'd0,8'd0, 1'b0,1'b0,8'd2,1'b1);      // back to RUN
    add(1'b1,1'b1,1'b0,8'd0,8'd0, 1'b0,1'b0,8'd3,1'b1);
    add(1'b1,1'b1,1'b0,8'd0,8'd0, 1'b1,1'b1,8'd0,1'b1);
    add(1'b1,1'b1,1'b0,8'd0,8'd0, 1'b1,1'b0,8'd1,1'b1);      // still running
    add(1'b0,1'b1,1'b1,8'd3,8'd0, 1'b1,1'b0,8'd1,1'b0);      // duty 0 pending
    add(1'b1,1'b1,1'b0,8'd0,8'd0, 1'b0,1'b0,8'd2,1'b0);
    add(1'b1,1'b1,1'b0,8'd0,8'd0, 1'b0,1'b0,8'd3,1'b0);
    add(1'b1,1'b1,1'b0,8'd0,8'd0, 1'b0,1'b1,8'd0,1'b1);
    for (int c = 1; c <= 3; c++)
      add(1'b1,1'b1,1'b0,8'd0,8'd0, 1'b0,1'b0,8'(c),1'b1);
    add(1'b1,1'b1,1'b1,8'd3,8'd9, 1'b0,1'b1,8'd0,1'b0);      // duty 9 on wrap
    for (int c = 1; c <= 3; c++)
      add(1'b1,1'b1,1'b0,8'd0,8'd0, 1'b0,1'b0,8'(c),1'b0);
    add(1'b1,1'b1,1'b0,8'd0,8'd0, 1'b1,1'b1,8'd0,1'b1);
    for (int c = 1; c <= 3; c++)
      add(1'b1,1'b1,1'b0,8'd0,8'd0, 1'b1,1'b0,8'(c),1'b1);
    add(1'b1,1'b1,1'b1,8'd0,8'd1, 1'b1,1'b1,8'd0,1'b0);      // period 0 on wrap
    for (int c = 1; c <= 3; c++)
      add(1'b1,1'b1,1'b0,8'd0,8'd0, 1'b1,1'b0,8'(c),1'b0);
    add(1'b1,1'b1,1'b0,8'd0,8'd0, 1'b1,1'b1,8'd0,1'b1);      // apply (0,1)
    add(1'b1,1'b1,1'b0,8'd0,8'd0, 1'b1,1'b1,8'd0,1'b1);
    add(1'b1,1'b1,1'b0,8'd0,8'd0, 1'b1,1'b1,8'd0,1'b1);
    add(1'b0,1'b1,1'b0,8'd0,8'd0, 1'b1,1'b0,8'd0,1'b1);
    add(1'b1,1'b1,1'b0,8'd0,8'd0, 1'b1,1'b1,8'd0,1'b1);

    // Reset state, then the table.
    #1;
    chk_all("in_reset", 1'b0, 1'b0, 8'd0, 1'b1);
    do_reset();
    chk_all("reset", 1'b0, 1'b0, 8'd0, 1'b1);
    foreach (vecs[i])
      step(vecs[i].t, vecs[i].e, vecs[i].v, vecs[i].p, vecs[i].d,
           vecs[i].ep, vecs[i].ed, vecs[i].ec, vecs[i].er, $sformatf("vec%0d", i));

    // Defaults, tick every 4th clk: pwm 1,1,0,0 per tick, done every 16 clk.
    do_reset();
    for (int k = 0; k < 64; k++) begin
      int t;
      logic exp_done;
      t = k / 4;
      exp_done = ((k % 4) == 0) && (t > 0) && ((t % 4) == 0);
      step((k % 4) == 0, 1'b1, 1'b0, 8'd0, 8'd0,
           ((t % 4) < 2), exp_done, 8'(t % 4), 1'b1, $sformatf("div_k%0d", k));
    end

    // Async reset mid-period with pwm high, then no config taken during reset.
    do_reset();
    step(1'b0,1'b0,1'b1,8'd3,8'd3, 1'b0,1'b0,8'd0,1'b1, "rst_load");
    step(1'b1,1'b1,1'b0,8'd0,8'd0, 1'b1,1'b0,8'd0,1'b1, "rst_c0");
    step(1'b1,1'b1,1'b0,8'd0,8'd0, 1'b1,1'b0,8'd1,1'b1, "rst_c1");
    step(1'b1,1'b1,1'b0,8'd0,8'd0, 1'b1,1'b0,8'd2,1'b1, "rst_c2");
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk_all("rst_async", 1'b0, 1'b0, 8'd0, 1'b1);
    tick_en = 1'b1; enable = 1'b1; cfg_valid = 1'b1; cfg_period = 8'd3; cfg_duty = 8'd0;
    @(posedge clk);
    #1;
    chk_all("rst_held", 1'b0, 1'b0, 8'd0, 1'b1);
    @(negedge clk);
    rst = 1'b0; cfg_valid = 1'b0; tick_en = 1'b0;
    step(1'b0,1'b1,1'b0,8'd0,8'd0, 1'b0,1'b0,8'd0,1'b1, "post_rst_idle");
    step(1'b1,1'b1,1'b0,8'd0,8'd0, 1'b1,1'b0,8'd0,1'b1, "post_rst_c0");
    step(1'b1,1'b1,1'b0,8'd0,8'd0, 1'b1,1'b0,8'd1,1'b1, "post_rst_c1");
    step(1'b1,1'b1,1'b0,8'd0,8'd0, 1'b0,1'b0,8'd2,1'b1, "post_rst_c2");
    step(1'b1,1'b1,1'b0,8'd0,8'd0, 1'b0,1'b0,8'd3,1'b1, "post_rst_c3");
    step(1'b1,1'b1,1'b0,8'd0,8'd0, 1'b1,1'b1,8'd0,1'b1, "post_rst_wrap");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
